// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 4-stage pipelined 8-bit processor.
//   This block owns the program counter and loads the IF/ID pipeline register.
//   Unconditional jumps (op 2'b11) are resolved here with zero penalty: the
//   jmp is consumed and a bubble goes downstream instead.
//
//   Clock            in   1  rising-edge clock
//   Reset            in   1  asynchronous active-low reset
//   PC               out  8  fetch address to instruction memory (the PC register)
//   Instruction_Code in   8  combinational memory read data at PC
//   Stall            in   1  hold PC and IF/ID contents
//   Redirect_En      in   1  flush IF/ID and refetch from Redirect_PC
//   Redirect_PC      in   8  redirect target
//   IFID_Instr       out  8  registered instruction to decode
//   IFID_PC          out  8  address of IFID_Instr
//   IFID_Valid       out  1  IFID_Instr is real (0 = bubble)
//   Halted           out  1  PC is past the end of the program
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int          IMEM_DEPTH = 6,
  parameter logic [7:0]  RESET_PC   = 8'h00
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] PC,
  input  logic [7:0] Instruction_Code,
  input  logic       Stall,
  input  logic       Redirect_En,
  input  logic [7:0] Redirect_PC,
  output logic [7:0] IFID_Instr,
  output logic [7:0] IFID_PC,
  output logic       IFID_Valid,
  output logic       Halted
);

  // One extra bit so a depth of 256 still compares correctly against an 8-bit PC.
  localparam logic [8:0] DEPTH_LIM = 9'(IMEM_DEPTH);

  // PC-relative jump target: 6-bit signed offset, result wraps mod 256.
  function automatic logic [7:0] jump_target(input logic [7:0] pc,
                                             input logic [7:0] instr);
    logic signed [7:0] off;
    off = {{2{instr[5]}}, instr[5:0]};
    return pc + off;
  endfunction

  logic       is_jmp;
  logic [7:0] pc_nxt;
  logic [7:0] instr_nxt;
  logic [7:0] ifpc_nxt;
  logic       vld_nxt;

  assign Halted = ({1'b0, PC} >= DEPTH_LIM);
  assign is_jmp = (Instruction_Code[7:6] == 2'b11);

  always_comb begin
    pc_nxt    = PC;
    instr_nxt = IFID_Instr;
    ifpc_nxt  = IFID_PC;
    vld_nxt   = IFID_Valid;
    if (Redirect_En) begin
      pc_nxt    = Redirect_PC;
      instr_nxt = 8'h00;
      ifpc_nxt  = 8'h00;
      vld_nxt   = 1'b0;
    end else if (Stall) begin
      // everything holds; a stalled jmp is re-evaluated once Stall drops
    end else if (Halted) begin
      instr_nxt = 8'h00;
      vld_nxt   = 1'b0;
    end else if (is_jmp) begin
      pc_nxt    = jump_target(PC, Instruction_Code);
      instr_nxt = 8'h00;
      ifpc_nxt  = PC;
      vld_nxt   = 1'b0;
    end else begin
      pc_nxt    = PC + 8'd1;
      instr_nxt = Instruction_Code;
      ifpc_nxt  = PC;
      vld_nxt   = 1'b1;
    end
  end

  // ---- IF -> ID boundary: PC and IF/ID pipeline register ----
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      PC         <= RESET_PC;
      IFID_Instr <= 8'h00;
      IFID_PC    <= 8'h00;
      IFID_Valid <= 1'b0;
    end else begin
      PC         <= pc_nxt;
      IFID_Instr <= instr_nxt;
      IFID_PC    <= ifpc_nxt;
      IFID_Valid <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc;
  logic [7:0] icode;
  logic       stall;
  logic       redir_en;
  logic [7:0] redir_pc;
  logic [7:0] ifid_instr;
  logic [7:0] ifid_pc;
  logic       ifid_vld;
  logic       halted;

  logic [7:0] mem [0:5];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         tag;
    logic [7:0] pc;
    logic       vld;
    logic [7:0] instr;
    logic [7:0] ifpc;
    logic       halt;
  } exp_t;

  exp_t q[$];
  exp_t e;

  fetch_stage #(.IMEM_DEPTH(6), .RESET_PC(8'h00)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .PC(pc),
    .Instruction_Code(icode),
    .Stall(stall),
    .Redirect_En(redir_en),
    .Redirect_PC(redir_pc),
    .IFID_Instr(ifid_instr),
    .IFID_PC(ifid_pc),
    .IFID_Valid(ifid_vld),
    .Halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational instruction memory; out-of-range reads return 0
  always_comb begin
    icode = 8'h00;
    if (pc < 8'd6) icode = mem[pc[2:0]];
  end

  // monitor: pops one expectation per edge, sampled 1 time unit after it
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (pc !== e.pc || ifid_vld !== e.vld || ifid_instr !== e.instr ||
          ifid_pc !== e.ifpc || halted !== e.halt) begin
        errors++;
        $display("FAIL step%0d got pc=%h v=%b instr=%h ifpc=%h h=%b want pc=%h v=%b instr=%h ifpc=%h h=%b",
                 e.tag, pc, ifid_vld, ifid_instr, ifid_pc, halted,
                 e.pc, e.vld, e.instr, e.ifpc, e.halt);
      end
    end
  end

  int tag = 0;

  // drive inputs for the next edge and queue the state expected after it
  task automatic cyc(input logic st, input logic re, input logic [7:0] rpc,
                     input logic [7:0] epc, input logic ev, input logic [7:0] ei,
                     input logic [7:0] eip, input logic eh);
    exp_t x;
    stall    = st;
    redir_en = re;
    redir_pc = rpc;
    tag++;
    x.tag = tag; x.pc = epc; x.vld = ev; x.instr = ei; x.ifpc = eip; x.halt = eh;
    q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_now(input string name, input logic [7:0] epc, input logic ev,
                         input logic [7:0] ei, input logic [7:0] eip, input logic eh);
    checks++;
    if (pc !== epc || ifid_vld !== ev || ifid_instr !== ei || ifid_pc !== eip || halted !== eh) begin
      errors++;
      $display("FAIL %s got pc=%h v=%b instr=%h ifpc=%h h=%b want pc=%h v=%b instr=%h ifpc=%h h=%b",
               name, pc, ifid_vld, ifid_instr, ifid_pc, halted, epc, ev, ei, eip, eh);
    end
  endtask

  localparam logic [7:0] I0 = 8'b00_010_011; // addi R2,3
  localparam logic [7:0] I1 = 8'b01_010_001; // sll  R2,1
  localparam logic [7:0] I2 = 8'b00_101_100; // addi R5,4
  localparam logic [7:0] I3 = 8'b11_000_010; // jmp  +2
  localparam logic [7:0] I4 = 8'b01_101_011; // sll  R5,3
  localparam logic [7:0] I5 = 8'b00_001_010; // addi R1,2

  initial begin
    mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = I3; mem[4] = I4; mem[5] = I5;
    rst_n = 1'b0; stall = 1'b0; redir_en = 1'b0; redir_pc = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk_now("reset_state", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;

    // straight-line program with forward jmp at 3 -> 5, then halt
    cyc(0, 0, 8'h00, 8'h01, 1, I0, 8'h00, 0);
    cyc(0, 0, 8'h00, 8'h02, 1, I1, 8'h01, 0);
    cyc(0, 0, 8'h00, 8'h03, 1, I2, 8'h02, 0);
    cyc(0, 0, 8'h00, 8'h05, 0, 8'h00, 8'h03, 0);
    cyc(0, 0, 8'h00, 8'h06, 1, I5, 8'h05, 1);
    cyc(0, 0, 8'h00, 8'h06, 0, 8'h00, 8'h05, 1);
    cyc(0, 0, 8'h00, 8'h06, 0, 8'h00, 8'h05, 1);

    // redirect with stall while halted: redirect wins and clears halt
    cyc(1, 1, 8'h02, 8'h02, 0, 8'h00, 8'h00, 0);
    cyc(0, 0, 8'h00, 8'h03, 1, I2, 8'h02, 0);
    cyc(0, 0, 8'h00, 8'h05, 0, 8'h00, 8'h03, 0);

    // stall at PC=1 with addr 0 in IF/ID, three cycles, then release
    cyc(0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    cyc(0, 0, 8'h00, 8'h01, 1, I0, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h01, 1, I0, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h01, 1, I0, 8'h00, 0);
    cyc(1, 0, 8'h00, 8'h01, 1, I0, 8'h00, 0);
    cyc(0, 0, 8'h00, 8'h02, 1, I1, 8'h01, 0);

    // stall while the jmp is being fetched: not taken until release
    cyc(0, 0, 8'h00, 8'h03, 1, I2, 8'h02, 0);
    cyc(1, 0, 8'h00, 8'h03, 1, I2, 8'h02, 0);
    cyc(1, 0, 8'h00, 8'h03, 1, I2, 8'h02, 0);
    cyc(0, 0, 8'h00, 8'h05, 0, 8'h00, 8'h03, 0);

    // backward jmp -2 at address 3
    mem[3] = 8'b11_111_110;
    cyc(0, 1, 8'h01, 8'h01, 0, 8'h00, 8'h00, 0);
    cyc(0, 0, 8'h00, 8'h02, 1, I1, 8'h01, 0);
    cyc(0, 0, 8'h00, 8'h03, 1, I2, 8'h02, 0);
    cyc(0, 0, 8'h00, 8'h01, 0, 8'h00, 8'h03, 0);
    cyc(0, 0, 8'h00, 8'h02, 1, I1, 8'h01, 0);

    // move to PC=4 then pulse reset asynchronously mid-cycle
    cyc(0, 1, 8'h04, 8'h04, 0, 8'h00, 8'h00, 0);
    cyc(0, 0, 8'h00, 8'h05, 1, I4, 8'h04, 0);
    cyc(0, 1, 8'h04, 8'h04, 0, 8'h00, 8'h00, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_now("async_reset", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    redir_en = 1'b0;
    @(posedge clk);
    #2;
    chk_now("no_fetch_in_reset", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

    // jmp -1 from address 0 wraps to 8'hFF, out of range -> halt, no fetch
    mem[0] = 8'b11_111_111;
    rst_n = 1'b1;
    cyc(0, 0, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 1);

    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 4-stage pipelined 8-bit processor; sits directly upstream of the instruction memory.
- Owns the program counter and drives it to the memory as PC. Samples the returned 8-bit Instruction_Code.
- Resolves unconditional jumps (opcode 2'b11) locally with zero penalty, and loads the IF/ID pipeline register consumed by decode.
- Supports downstream stall, a redirect/flush request from later stages, and halts at end of program.

Parameters:
- IMEM_DEPTH, 6, number of valid instruction words; PC >= IMEM_DEPTH means end of program.
- RESET_PC, 8'h00, PC value loaded during reset.

Ports:
- Clock  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset==0 resets immediately, independent of Clock).
- PC  output  8  current fetch address to instruction memory; this is the PC register itself.
- Instruction_Code  input  8  combinational read data from instruction memory at PC.
- Stall  input  1  from hazard unit; hold PC and IF/ID contents.
- Redirect_En  input  1  later-stage request to flush IF/ID and refetch from Redirect_PC.
- Redirect_PC  input  8  redirect target.
- IFID_Instr  output  8  registered instruction to decode.
- IFID_PC  output  8  registered address of IFID_Instr.
- IFID_Valid  output  1  IFID_Instr is a real instruction; decode treats 0 as bubble.
- Halted  output  1  high while PC >= IMEM_DEPTH; combinational from PC register.

Behaviour:
- Reset (Reset==0, async):
  - PC=RESET_PC, IFID_Instr=8'h00, IFID_PC=8'h00, IFID_Valid=0.
  - Halted follows PC, so it is 0 for the default parameters.
  - No fetch occurs while Reset is low; this lets the memory complete its reset-time load.
  - Reset asserted mid-operation discards all state immediately, including any pending redirect or stall.
- Instruction decode within fetch:
  - op = Instruction_Code[7:6].
  - If op == 2'b11 (jmp), off6 = Instruction_Code[5:0], sign-extended to 8 bits.
  - Jump target = PC + sext(off6), mod 256.
- Per rising edge, Reset high, evaluated in this priority order:
  1. Redirect_En=1: PC<=Redirect_PC; IFID_Valid<=0; IFID_Instr<=8'h00; IFID_PC<=8'h00. Overrides Stall and Halted.
  2. Stall=1: PC, IFID_Instr, IFID_PC and IFID_Valid all hold.
  3. Halted=1: PC holds; IFID_Valid<=0; IFID_Instr<=8'h00.
  4. Fetched instruction is jmp: PC<=jump target; IFID_Valid<=0 (the jmp is consumed in IF, bubble sent downstream); IFID_PC<=PC; IFID_Instr<=8'h00.
  5. Otherwise: IFID_Instr<=Instruction_Code; IFID_PC<=PC; IFID_Valid<=1; PC<=PC+1 (8-bit wrap, 8'hFF -> 8'h00).
- Latency:
  - An instruction appears on IFID_* one edge after PC addresses it.
  - Taken jmp costs one bubble cycle; the target is fetched on the next edge.
- Jump to a target >= IMEM_DEPTH: Halted asserts the next cycle; no fetch occurs from the out-of-range address.
- Halt is cleared only by Redirect_En to an in-range PC, or by reset.
- Stall during a jmp fetch: jmp is not taken until Stall drops; the jmp is then re-evaluated.
- Stall and Redirect_En both high: redirect wins.

Test Plan:
- Reset release, memory loaded with the 6-word program (addi R2,3 / sll R2,1 / addi R5,4 / jmp +2 / sll R5,3 / addi R1,2) -> edges 1-3 give IFID_Instr=8'b00_010_011, 8'b01_010_001, 8'b00_101_100 with IFID_PC=0,1,2 and Valid=1.
- Same run, edge 4 -> IFID_Valid=0 and PC=5; edge 5 -> IFID_Instr=8'b00_001_010, IFID_PC=5; edge 6 -> PC=6, Halted=1, Valid=0 thereafter. 8'b01_101_011 at address 4 is never issued.
- Stall held 3 cycles with PC=1 -> PC stays 1 and IFID_* stay frozen at addr 0's contents; on Stall release the next edge loads Mem[1].
- Redirect_En=1, Redirect_PC=8'h02 with Stall=1 while Halted -> next edge PC=2, Valid=0, Halted=0; following edge IFID_Instr=8'b00_101_100.
- Backward jmp: Mem[3]=8'b11_111_110 (off -2) -> PC goes 3 -> 1; IFID shows a bubble then Mem[1].
- Reset pulsed low asynchronously mid-cycle at PC=4 -> PC=0 and IFID_Valid=0 immediately, without waiting for a clock edge.
